// File: rtl/fetch_unit.sv
// Instruction fetch: one req/ack read per free queue slot, results buffered with their PCs.
// Latency pc_en->if_valid 2 cycles min (+memory waits); launches stall while the queue is full.

module fetch_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         vld,
   output logic         full,
   output logic [W-1:0] head_dat
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_dat;
   end

   // clear outranks any same-cycle push or pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   assign vld      = (count != '0);
   assign full     = (count == CW'(DEPTH));
   assign head_dat = mem[rd_ptr];
endmodule

module fetch_unit #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 32,
   parameter int QDEPTH  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic               pc_en,
   input  logic               flush,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc
);
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t state;
   state_t state_nxt;
   logic   req_nxt;
   logic   launch;
   logic   push;
   logic   pop;
   logic   q_vld;
   logic   q_full;
   entry_t push_entry;
   entry_t head;

   // DROP keeps the request up until the memory acks, since a request is never withdrawn
   always_comb begin
      state_nxt = state;
      req_nxt   = imem_req;
      launch    = 1'b0;
      push      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!q_full && !flush) begin
               launch    = 1'b1;
               req_nxt   = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_ack) begin
               push      = !flush;
               req_nxt   = 1'b0;
               state_nxt = S_IDLE;
            end else if (flush) begin
               state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_ack) begin
               req_nxt   = 1'b0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            req_nxt   = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         state    <= state_nxt;
         imem_req <= req_nxt;
         if (launch) imem_addr <= pc_in;
      end
   end

   assign pc_en      = launch & reset;
   assign pop        = q_vld & if_ready;
   assign push_entry = '{pc: imem_addr, instr: imem_rdata};

   fetch_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pop),
      .vld      (q_vld),
      .full     (q_full),
      .head_dat (head)
   );

   assign if_valid = q_vld;
   assign if_instr = q_vld ? head.instr : INSTR_W'(32'h0000_0013);
   assign if_pc    = q_vld ? head.pc : '0;
endmodule
